// File: rtl/effect_ctrl_pkg.sv
// Shared types and per-parameter tables for the effect parameter controller.
// Index i of each table describes value[i]; up to MAX_PARAM parameters are supported.
package effect_ctrl_pkg;

    typedef enum logic {
        LINEAR,
        TIERED
    } param_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        REPEAT
    } key_state_e;

    localparam int MAX_PARAM = 16;

    localparam longint TIER_B0 = 100;
    localparam longint TIER_B1 = 500;
    localparam longint TIER_B2 = 1000;
    localparam int TIER_S0 = 10;
    localparam int TIER_S1 = 50;
    localparam int TIER_S2 = 100;
    localparam int TIER_S3 = 500;

    localparam int P_MIN [MAX_PARAM] = '{
        0, 1, 1, -1000, -1000, -1000, -1000, -1000,
        -1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000
    };
    localparam int P_MAX [MAX_PARAM] = '{
        2000, 50, 50, 1000, 1000, 1000, 1000, 1000,
        1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000
    };
    localparam int P_DEF [MAX_PARAM] = '{
        90, 1, 49, 1000, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0
    };
    localparam param_mode_e P_MODE [MAX_PARAM] = '{
        TIERED, LINEAR, LINEAR, TIERED, LINEAR, LINEAR, LINEAR, LINEAR,
        LINEAR, LINEAR, LINEAR, LINEAR, LINEAR, LINEAR, LINEAR, LINEAR
    };

    // Decrement tiers use <= so a step down from a boundary uses the finer size.
    function automatic int step_size(param_mode_e mode, logic up, longint v);
        int s;
        s = 1;
        if (mode == TIERED) begin
            if (up) begin
                if (v < TIER_B0)      s = TIER_S0;
                else if (v < TIER_B1) s = TIER_S1;
                else if (v < TIER_B2) s = TIER_S2;
                else                  s = TIER_S3;
            end else begin
                if (v <= TIER_B0)      s = TIER_S0;
                else if (v <= TIER_B1) s = TIER_S1;
                else if (v <= TIER_B2) s = TIER_S2;
                else                   s = TIER_S3;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/effect_param_controller_key_repeat.sv
// One push key: 2-flop synchroniser, debounce FSM and auto-repeat timer.
// step_o pulses for one cycle on acceptance and on every repeat.
module key_repeat
    import effect_ctrl_pkg::*;
#(
    parameter int DEB_CYC = 500000,
    parameter int REP_DLY = 25000000,
    parameter int REP_PER = 5000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic key_n_i,
    output logic step_o
);

    localparam int MAX_A   = (DEB_CYC > REP_DLY) ? DEB_CYC : REP_DLY;
    localparam int MAX_CYC = (MAX_A > REP_PER) ? MAX_A : REP_PER;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REP_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REP_PER - 1);

    logic             sync1_q, sync2_q;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_cnt_q <= '0;
        end else begin
            sync1_q  <= key_n_i;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_cnt_q <= hi_cnt_d;
        end
    end

    // The IDLE cycle that first sees the key low counts as the first low cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_cnt_d = hi_cnt_q;
        step_o   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                hi_cnt_d = '0;
                if (!sync2_q) begin
                    state_d = DEBOUNCE;
                    cnt_d   = CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    step_o  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD, REPEAT: begin
                // A high glitch pauses the repeat timer rather than restarting it.
                if (sync2_q) begin
                    if (hi_cnt_q == DEB_LAST) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        hi_cnt_d = '0;
                    end else begin
                        hi_cnt_d = hi_cnt_q + CNT_W'(1);
                    end
                end else begin
                    hi_cnt_d = '0;
                    if (cnt_q == ((state_q == HELD) ? DLY_LAST : PER_LAST)) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        step_o  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/effect_param_controller.sv
// Key-driven editor for N_PARAM signed effect parameters with per-parameter
// step modes and saturation limits taken from effect_ctrl_pkg.
module effect_param_controller
    import effect_ctrl_pkg::*;
#(
    parameter int N_PARAM = 4,
    parameter int VAL_W   = 32,
    parameter int DEB_CYC = 500000,
    parameter int REP_DLY = 25000000,
    parameter int REP_PER = 5000000
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            key3,
    input  logic                            key2,
    input  logic [9:0]                      SW,
    output logic [N_PARAM-1:0][VAL_W-1:0]   value,
    output logic                            disabled,
    output logic                            changed
);

    localparam logic [4:0] N_LIM = 5'(N_PARAM);

    // {SW[9], SW[3:0]}; the remaining switches have no function.
    logic [4:0] sw_s1_q, sw_s2_q;
    logic       unused_sw;
    logic       inc_step, dec_step;
    logic       step_any, up;
    logic [3:0] sel;
    logic       sel_ok;

    logic [N_PARAM-1:0][VAL_W-1:0] value_q, value_d;
    logic [N_PARAM-1:0]            chg;
    logic                          disabled_q, changed_q;

    assign unused_sw = ^SW[8:4];

    key_repeat #(
        .DEB_CYC(DEB_CYC),
        .REP_DLY(REP_DLY),
        .REP_PER(REP_PER)
    ) u_inc (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .key_n_i(key2),
        .step_o (inc_step)
    );

    key_repeat #(
        .DEB_CYC(DEB_CYC),
        .REP_DLY(REP_DLY),
        .REP_PER(REP_PER)
    ) u_dec (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .key_n_i(key3),
        .step_o (dec_step)
    );

    // Simultaneous increment and decrement cancel each other.
    assign step_any = inc_step ^ dec_step;
    assign up       = inc_step;
    assign sel      = sw_s2_q[3:0];
    assign sel_ok   = ({1'b0, sel} < N_LIM);

    for (genvar gi = 0; gi < N_PARAM; gi++) begin : g_param
        logic signed [VAL_W:0] old_w, step_w, sum_w, min_w, max_w, clamp_w;
        logic                  hit;

        assign old_w  = {value_q[gi][VAL_W-1], value_q[gi]};
        assign step_w = (VAL_W+1)'(step_size(P_MODE[gi], up, longint'($signed(value_q[gi]))));
        assign min_w  = (VAL_W+1)'(P_MIN[gi]);
        assign max_w  = (VAL_W+1)'(P_MAX[gi]);
        assign sum_w  = up ? (old_w + step_w) : (old_w - step_w);

        always_comb begin
            clamp_w = sum_w;
            if (sum_w < min_w)      clamp_w = min_w;
            else if (sum_w > max_w) clamp_w = max_w;
        end

        assign hit          = step_any && sel_ok && (sel == 4'(gi));
        assign value_d[gi]  = hit ? clamp_w[VAL_W-1:0] : value_q[gi];
        assign chg[gi]      = hit && (clamp_w != old_w);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sw_s1_q    <= '1;
            sw_s2_q    <= '1;
            disabled_q <= 1'b1;
            changed_q  <= 1'b0;
            for (int i = 0; i < N_PARAM; i++) begin
                value_q[i] <= VAL_W'(P_DEF[i]);
            end
        end else begin
            sw_s1_q    <= {SW[9], SW[3:0]};
            sw_s2_q    <= sw_s1_q;
            disabled_q <= ~sw_s2_q[4];
            changed_q  <= |chg;
            value_q    <= value_d;
        end
    end

    assign value    = value_q;
    assign disabled = disabled_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_effect_param_controller.sv
// Self-checking bench: scoreboard of expected value changes checked on each
// changed pulse, a table of single-press vectors, and hand-written hold sequences.
module tb_effect_param_controller;

    localparam int NP   = 4;
    localparam int VW   = 32;
    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 5;

    logic                  CLK   = 1'b0;
    logic                  RST_N = 1'b0;
    logic                  key2  = 1'b1;
    logic                  key3  = 1'b1;
    logic [9:0]            SW    = '0;
    logic [NP-1:0][VW-1:0] value;
    logic                  disabled;
    logic                  changed;

    effect_param_controller #(
        .N_PARAM(NP),
        .VAL_W  (VW),
        .DEB_CYC(DEB),
        .REP_DLY(RDLY),
        .REP_PER(RPER)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .key3    (key3),
        .key2    (key2),
        .SW      (SW),
        .value   (value),
        .disabled(disabled),
        .changed (changed)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    typedef struct {
        bit       inc;
        bit [3:0] sel;
        bit       sw9;
        int       chk;
        int       val;
        bit       chg;
    } vec_t;

    exp_t exp_q[$];
    int   chg_log[$];
    vec_t tbl[13];
    int   pdef[NP] = '{90, 1, 49, 1000};
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int val_of(input int i);
        return $signed(value[i]);
    endfunction

    // Every changed pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (mon_en && changed) begin
            exp_t e;
            chg_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_changed", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("changed_value_p%0d", e.idx), val_of(e.idx), e.val);
            end
        end
    end

    task automatic press(input bit up, input bit dn, input int hold);
        key2 = up ? 1'b0 : 1'b1;
        key3 = dn ? 1'b0 : 1'b1;
        repeat (hold) @(negedge CLK);
        key2 = 1'b1;
        key3 = 1'b1;
        repeat (12) @(negedge CLK);
    endtask

    task automatic wait_q(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic select(input bit sw9, input bit [3:0] sel);
        SW = {sw9, 5'd0, sel};
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        int rel;
        tbl[0]  = '{1'b1, 4'd0, 1'b1, 0, 100,  1'b1};
        tbl[1]  = '{1'b1, 4'd0, 1'b1, 0, 150,  1'b1};
        tbl[2]  = '{1'b1, 4'd0, 1'b0, 0, 200,  1'b1};
        tbl[3]  = '{1'b0, 4'd0, 1'b0, 0, 150,  1'b1};
        tbl[4]  = '{1'b0, 4'd1, 1'b1, 1, 1,    1'b0};
        tbl[5]  = '{1'b1, 4'd1, 1'b1, 1, 2,    1'b1};
        tbl[6]  = '{1'b1, 4'd3, 1'b0, 3, 1000, 1'b0};
        tbl[7]  = '{1'b0, 4'd3, 1'b0, 3, 900,  1'b1};
        tbl[8]  = '{1'b1, 4'd3, 1'b1, 3, 1000, 1'b1};
        tbl[9]  = '{1'b1, 4'd5, 1'b1, 0, 150,  1'b0};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 0, 100,  1'b1};
        tbl[11] = '{1'b0, 4'd0, 1'b0, 0, 90,   1'b1};
        tbl[12] = '{1'b0, 4'd0, 1'b1, 0, 80,   1'b1};

        repeat (3) @(negedge CLK);
        for (int i = 0; i < NP; i++) check($sformatf("reset_value_p%0d", i), val_of(i), pdef[i]);
        check("reset_disabled", disabled, 1);
        check("reset_changed", changed, 0);
        RST_N  = 1'b1;
        mon_en = 1'b1;

        // Three low cycles are not enough to be accepted.
        select(1'b0, 4'd0);
        press(1'b1, 1'b0, DEB - 1);
        check("short_press_value", val_of(0), 90);
        $display("seq short_press p0=%0d", val_of(0));

        // Long hold into P_MAX: one change, then saturation without pulses.
        select(1'b0, 4'd2);
        exp_q.push_back(exp_t'{2, 50});
        press(1'b1, 1'b0, 40);
        wait_q("sat_drained", 20);
        check("sat_value", val_of(2), 50);
        $display("seq saturate p2=%0d", val_of(2));

        for (int r = 0; r < 13; r++) begin
            select(tbl[r].sw9, tbl[r].sel);
            if (tbl[r].chg) exp_q.push_back(exp_t'{tbl[r].chk, tbl[r].val});
            press(tbl[r].inc, !tbl[r].inc, 8);
            wait_q($sformatf("vec%0d_drained", r), 20);
            check($sformatf("vec%0d_value", r), val_of(tbl[r].chk), tbl[r].val);
            check($sformatf("vec%0d_disabled", r), disabled, !tbl[r].sw9);
            $display("vec %0d sel=%0d inc=%0d p%0d=%0d", r, tbl[r].sel, tbl[r].inc,
                     tbl[r].chk, val_of(tbl[r].chk));
        end

        // Auto-repeat timing: acceptance, then +REP_DLY, +REP_DLY+REP_PER, ...
        select(1'b0, 4'd1);
        chg_log.delete();
        for (int v = 3; v <= 6; v++) exp_q.push_back(exp_t'{1, v});
        press(1'b1, 1'b0, 36);
        wait_q("repeat_drained", 20);
        check("repeat_count", chg_log.size(), 4);
        if (chg_log.size() == 4) begin
            check("repeat_gap1", chg_log[1] - chg_log[0], RDLY);
            check("repeat_gap2", chg_log[2] - chg_log[0], RDLY + RPER);
            check("repeat_gap3", chg_log[3] - chg_log[0], RDLY + 2 * RPER);
        end
        $display("seq repeat p1=%0d", val_of(1));

        // Selection change mid-hold retargets the next repeat step.
        select(1'b0, 4'd1);
        exp_q.push_back(exp_t'{1, 7});
        exp_q.push_back(exp_t'{0, 90});
        key2 = 1'b0;
        repeat (10) @(negedge CLK);
        SW = 10'd0;
        repeat (18) @(negedge CLK);
        key2 = 1'b1;
        repeat (12) @(negedge CLK);
        wait_q("retarget_drained", 20);
        check("retarget_p1", val_of(1), 7);
        check("retarget_p0", val_of(0), 90);
        $display("seq retarget p0=%0d p1=%0d", val_of(0), val_of(1));

        // Both keys accepted together: no change.
        select(1'b0, 4'd1);
        press(1'b1, 1'b1, 8);
        check("both_keys_value", val_of(1), 7);
        $display("seq both_keys p1=%0d", val_of(1));

        // Reset in the middle of auto-repeat, key still held afterwards.
        select(1'b1, 4'd1);
        for (int v = 8; v <= 10; v++) exp_q.push_back(exp_t'{1, v});
        key2 = 1'b0;
        repeat (33) @(negedge CLK);
        check("pre_reset_value", val_of(1), 10);
        check("pre_reset_disabled", disabled, 0);
        check("pre_reset_drained", exp_q.size(), 0);
        RST_N = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < NP; i++) check($sformatf("midrst_value_p%0d", i), val_of(i), pdef[i]);
        check("midrst_disabled", disabled, 1);
        check("midrst_changed", changed, 0);
        RST_N = 1'b1;
        rel   = cyc;
        chg_log.delete();
        exp_q.push_back(exp_t'{1, 2});
        wait_q("post_reset_drained", 40);
        check("post_reset_fresh_debounce",
              (chg_log.size() > 0) && ((chg_log[0] - rel) >= DEB + 1), 1);
        key2 = 1'b1;
        repeat (12) @(negedge CLK);
        check("post_reset_value", val_of(1), 2);
        $display("seq reset_mid_repeat p1=%0d", val_of(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
